// File: rtl/dmem_arbiter_if.sv
// Requester handshakes and memory port shared by the two masters, the arbiter and Data_Memory.
// slave = arbiter side; master = requesters plus memory side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              r0_req,   r1_req;
  logic              r0_we,    r1_we;
  logic [ADDR_W-1:0] r0_addr,  r1_addr;
  logic [DATA_W-1:0] r0_wdata, r1_wdata;
  logic              r0_ack,   r1_ack;
  logic [DATA_W-1:0] r0_rdata, r1_rdata;
  logic              r0_err,   r1_err;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Write_Data;
  logic              MemWrite;
  logic              MemRead;
  logic [DATA_W-1:0] Read_Data;

  modport slave (
    input  r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata, Read_Data,
    output r0_ack, r1_ack, r0_rdata, r1_rdata, r0_err, r1_err,
           Mem_Addr, Write_Data, MemWrite, MemRead
  );

  modport master (
    output r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata, Read_Data,
    input  r0_ack, r1_ack, r0_rdata, r1_rdata, r0_err, r1_err,
           Mem_Addr, Write_Data, MemWrite, MemRead
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-requester arbiter and access sequencer for the single-ported Data_Memory.
// Optional address range/alignment rejection: define DMEM_ARB_CHECK_EN.
module dmem_arbiter #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = 64
) (
  input  logic            clk,
  input  logic            reset,
  dmem_arbiter_if.slave   bus,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  if (MEM_BYTES < 8) begin : g_bad_mem_bytes
    $error("dmem_arbiter: MEM_BYTES must hold at least one double word");
  end

  state_t            state, state_nx;
  logic              prio;
  logic              g_id;
  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic [DATA_W-1:0] rdata0, rdata1;

  logic              grant;
  logic              gnt_id;
  logic              gnt_bad;

  always_comb begin
    grant  = bus.r0_req | bus.r1_req;
    gnt_id = (bus.r0_req & bus.r1_req) ? prio : bus.r1_req;
  end

`ifdef DMEM_ARB_CHECK_EN
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(MEM_BYTES - 8);
  logic [ADDR_W-1:0] gnt_addr;
  logic              g_err;

  always_comb begin
    gnt_addr = gnt_id ? bus.r1_addr : bus.r0_addr;
    gnt_bad  = (gnt_addr[2:0] != 3'b000) || (gnt_addr > ADDR_MAX);
  end
`else
  always_comb gnt_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (grant) state_nx = gnt_bad ? RESP : ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes and acks come from state and latched fields only, so a reset
  // mid-ACCESS removes MemWrite before the closing edge.
  always_comb begin
    busy           = (state != IDLE);
    bus.Mem_Addr   = '0;
    bus.Write_Data = '0;
    bus.MemWrite   = 1'b0;
    bus.MemRead    = 1'b0;
    bus.r0_ack     = 1'b0;
    bus.r1_ack     = 1'b0;
    if (state == ACCESS) begin
      bus.Mem_Addr   = g_addr;
      bus.Write_Data = g_wdata;
      bus.MemWrite   = g_we;
      bus.MemRead    = ~g_we;
    end
    if (state == RESP) begin
      bus.r0_ack = ~g_id;
      bus.r1_ack = g_id;
    end
  end

`ifdef DMEM_ARB_CHECK_EN
  always_comb begin
    bus.r0_err = bus.r0_ack & g_err;
    bus.r1_err = bus.r1_ack & g_err;
  end
`else
  always_comb begin
    bus.r0_err = 1'b0;
    bus.r1_err = 1'b0;
  end
`endif

  always_comb begin
    bus.r0_rdata = rdata0;
    bus.r1_rdata = rdata1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio    <= 1'b0;
      g_id    <= 1'b0;
      g_we    <= 1'b0;
      g_addr  <= '0;
      g_wdata <= '0;
      rdata0  <= '0;
      rdata1  <= '0;
`ifdef DMEM_ARB_CHECK_EN
      g_err   <= 1'b0;
`endif
    end else if (state == IDLE && grant) begin
      prio    <= ~gnt_id;
      g_id    <= gnt_id;
      g_we    <= gnt_id ? bus.r1_we    : bus.r0_we;
      g_addr  <= gnt_id ? bus.r1_addr  : bus.r0_addr;
      g_wdata <= gnt_id ? bus.r1_wdata : bus.r0_wdata;
`ifdef DMEM_ARB_CHECK_EN
      g_err   <= gnt_bad;
      if (gnt_bad) begin
        if (gnt_id) rdata1 <= '0;
        else        rdata0 <= '0;
      end
`endif
    end else if (state == ACCESS && !g_we) begin
      if (g_id) rdata1 <= bus.Read_Data;
      else      rdata0 <= bus.Read_Data;
    end
  end

endmodule
